delay_arr: RTL and testbench
============================

Name: delay_arr

Overview:
- Fixed-latency pipeline delay line: a WIDTH-bit word entering on `in` appears on `out` exactly DELAY clock cycles later.
- Built as an array of DELAY registers, shifted every rising clock edge.
- Used throughout the pipelined MIPS datapath to align control and data signals across stages.
- No handshake, no stall; the line advances every cycle.

Parameters:
- WIDTH, 1, bit width of the data word; legal range ≥1.
- DELAY, 1, number of register stages (cycles of latency); legal range ≥0.
- RESET_VALUE, 0 (WIDTH bits), value loaded into every stage on reset.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; the codebase carries it as the control bundle's Reset field, driven low to reset.
- in  input  WIDTH  data word sampled each rising clock edge.
- out  output  WIDTH  data word delayed by DELAY cycles.

Behaviour:
- Storage: stage[0..DELAY-1], each WIDTH bits.
- Every rising edge with reset high: stage[0] <= in; stage[i] <= stage[i-1] for i = 1..DELAY-1.
- out = stage[DELAY-1]; it is a register output with no combinational path from `in` when DELAY ≥ 1.
- Latency: a value presented on `in` before rising edge k appears on `out` after rising edge k+DELAY-1, i.e. it is visible for the cycle following that edge. Equivalently, out(cycle n) = in(cycle n-DELAY).
- Reset:
  - reset low asynchronously forces all stages to RESET_VALUE immediately, without waiting for a clock edge.
  - out = RESET_VALUE while reset is low.
  - Reset is not clock-gated; asserting it mid-operation discards all in-flight words.
- Release from reset:
  - The first rising edge with reset high captures `in` into stage[0].
  - out shows RESET_VALUE for the first DELAY-1 edges after release, then valid delayed data.
- DELAY = 0: pure combinational passthrough, out = in. No registers; reset and clock have no effect.
- DELAY = 1: a single register.
- Throughput: one word per cycle, continuously. No bubbles are inserted and no words are dropped while reset is high.
- Widths: data is copied bit-exact with no arithmetic; every bit of WIDTH is preserved, including MSB and all-ones patterns.
- Reset asserted on the same instant as a clock edge: reset wins and stages hold RESET_VALUE.

Test Plan:
- WIDTH=4, DELAY=2, clock period 2, `in` starting at 0 and incrementing by 1 each cycle, reset low for the first 2 cycles → out=0 during reset. After release out trails in by exactly 2 cycles (in=5 seen on out two edges later), including the 4'hF→4'h0 wrap.
- Reset pulse mid-stream (drop reset low asynchronously between edges with out=7) → out=0 immediately, before the next edge. After release out=0 for one edge, then shows the captured `in` values.
- DELAY=0, WIDTH=8: drive in=8'hA5 then 8'h3C with no clock → out follows combinationally (A5, then 3C). Reset low has no effect.
- DELAY=1, WIDTH=1, RESET_VALUE=1: reset → out=1. Drive alternating 0/1 → out shows the same pattern one cycle late.
- DELAY=5, WIDTH=32, random stream of 100 words (including 32'hFFFF_FFFF and 32'h8000_0000) → out(n) == in(n-5) for all n≥5 after reset release; out = RESET_VALUE for the first 4 edges.

Source files
------------

// File: rtl/delay_arr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// delay_arr : fixed-latency delay line, DELAY register stages of WIDTH bits
// Revision  : 1.0
// ----------------------------------------------------------------------------
module delay_arr #(
   parameter int               WIDTH       = 1,
   parameter int               DELAY       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   generate
      if (DELAY == 0) begin : g_passthru
         // Clock and reset are intentionally ignored with zero stages.
         logic unused_w;
         assign unused_w = clock ^ reset;
         assign out      = in;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DELAY];
         logic [WIDTH-1:0] stage_d [DELAY];

         always_comb begin
            stage_d[0] = in;
            for (int i = 1; i < DELAY; i++) begin
               stage_d[i] = stage_q[i-1];
            end
         end

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < DELAY; i++) begin
                  stage_q[i] <= RESET_VALUE;
               end
            end else begin
               for (int i = 0; i < DELAY; i++) begin
                  stage_q[i] <= stage_d[i];
               end
            end
         end

         assign out = stage_q[DELAY-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_delay_arr.sv
`timescale 1ns/100ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_delay_arr : self-checking bench for delay_arr across four configurations
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_delay_arr;

   localparam logic [31:0] C_RV_D = 32'h0BAD_F00D;

   logic clk = 1'b0;
   always #1 clk = ~clk;

   logic        rst_a, rst_b, rst_c, rst_d;
   logic [3:0]  in_a, out_a;
   logic [7:0]  in_b, out_b;
   logic        in_c, out_c;
   logic [31:0] in_d, out_d;

   delay_arr #(.WIDTH(4),  .DELAY(2), .RESET_VALUE(4'h0)) u_a (
      .clock(clk), .reset(rst_a), .in(in_a), .out(out_a));
   delay_arr #(.WIDTH(8),  .DELAY(0), .RESET_VALUE(8'h00)) u_b (
      .clock(clk), .reset(rst_b), .in(in_b), .out(out_b));
   delay_arr #(.WIDTH(1),  .DELAY(1), .RESET_VALUE(1'b1)) u_c (
      .clock(clk), .reset(rst_c), .in(in_c), .out(out_c));
   delay_arr #(.WIDTH(32), .DELAY(5), .RESET_VALUE(C_RV_D)) u_d (
      .clock(clk), .reset(rst_d), .in(in_d), .out(out_d));

   typedef struct {
      logic        rst;
      logic [31:0] din;
      logic [31:0] exp;
   } vec_t;

   vec_t        tab_a [20];
   vec_t        tab_c [8];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      rst_a = 1'b0; rst_b = 1'b1; rst_c = 1'b0; rst_d = 1'b0;
      in_a = '0; in_b = '0; in_c = 1'b0; in_d = '0;

      // After edge i the 2-stage line shows the word driven at step i-1.
      for (int i = 0; i < 20; i++) begin
         tab_a[i].rst = (i >= 2);
         tab_a[i].din = 32'(i) & 32'hF;
         tab_a[i].exp = (i >= 3) ? (32'(i - 1) & 32'hF) : 32'h0;
      end
      tab_c[0] = '{1'b1, 32'h0, 32'h0};
      tab_c[1] = '{1'b1, 32'h1, 32'h1};
      tab_c[2] = '{1'b1, 32'h0, 32'h0};
      tab_c[3] = '{1'b1, 32'h1, 32'h1};
      tab_c[4] = '{1'b1, 32'h1, 32'h1};
      tab_c[5] = '{1'b1, 32'h0, 32'h0};
      tab_c[6] = '{1'b0, 32'h0, 32'h1};
      tab_c[7] = '{1'b1, 32'h0, 32'h0};

      @(negedge clk);
      check("a_reset", 32'(out_a), 32'h0);
      check("c_reset", 32'(out_c), 32'h1);
      check("d_reset", out_d, C_RV_D);

      for (int i = 0; i < 20; i++) begin
         rst_a = tab_a[i].rst;
         in_a  = tab_a[i].din[3:0];
         @(posedge clk); @(negedge clk);
         check($sformatf("a_vec%0d", i), 32'(out_a), tab_a[i].exp);
      end

      // Asynchronous reset between edges while out holds 7.
      in_a = 4'd7;
      @(posedge clk); @(negedge clk);
      in_a = 4'd8;
      @(posedge clk); @(negedge clk);
      check("a_pre_pulse", 32'(out_a), 32'h7);
      #0.3 rst_a = 1'b0;
      #0.2 check("a_async_rst", 32'(out_a), 32'h0);
      @(posedge clk); @(negedge clk);
      check("a_held_rst", 32'(out_a), 32'h0);
      rst_a = 1'b1; in_a = 4'd9;
      @(posedge clk); @(negedge clk);
      check("a_release1", 32'(out_a), 32'h0);
      in_a = 4'd10;
      @(posedge clk); @(negedge clk);
      check("a_release2", 32'(out_a), 32'h9);

      in_b = 8'hA5;
      #0.2 check("b_a5", 32'(out_b), 32'hA5);
      in_b = 8'h3C;
      #0.2 check("b_3c", 32'(out_b), 32'h3C);
      rst_b = 1'b0;
      #0.2 check("b_rst_ignored", 32'(out_b), 32'h3C);
      in_b = 8'hFF;
      #0.2 check("b_ff", 32'(out_b), 32'hFF);
      rst_b = 1'b1;

      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rst_c = tab_c[i].rst;
         in_c  = tab_c[i].din[0];
         @(posedge clk); @(negedge clk);
         check($sformatf("c_vec%0d", i), 32'(out_c), tab_c[i].exp);
      end

      for (int n = 0; n < 100; n++) begin
         rst_d = 1'b1;
         case (n)
            10:      w = 32'hFFFF_FFFF;
            11:      w = 32'h8000_0000;
            12:      w = 32'h0000_0000;
            default: w = $urandom;
         endcase
         in_d = w;
         sb.push_back(w);
         @(posedge clk); @(negedge clk);
         if (n >= 4) check($sformatf("d_word%0d", n), out_d, sb.pop_front());
         else        check($sformatf("d_fill%0d", n), out_d, C_RV_D);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
